program_counter_stack: RTL

Parametrised successor to the 16-bit program counter for the SAP-II datapath. It adds a hardware return-address stack so CALL and RET execute without memory cycles. It supports a configurable width, stack depth and end-of-range wrap mode, and reports stack and count errors. It sits on WBUS beside the MAR and is driven by the controller-sequencer's control word.

---
 rtl/program_counter_stack_pkg.sv | 21 ++
 rtl/program_counter_stack_stack.sv | 74 +++++++
 rtl/program_counter_stack.sv | 114 +++++++++++
 3 files changed

// File: rtl/program_counter_stack_pkg.sv
// rtl/program_counter_stack_pkg.sv - shared constants for the program counter with return stack
//
// Purpose: error flag bit positions, default sizing and a helper for
// stack pointer width. Imported by program_counter_stack and return_stack.
package program_counter_stack_pkg;

  // ERR flag bit positions
  localparam int ERR_OVF = 0;
  localparam int ERR_UNF = 1;
  localparam int ERR_SAT = 2;

  // Default sizing
  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;

  // Stack pointer needs one extra bit so that SP can hold DEPTH itself
  function automatic int sp_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/program_counter_stack_stack.sv
// rtl/program_counter_stack_stack.sv - DEPTH x WIDTH return-address LIFO
//
// Purpose: hardware return stack. push writes din at SP and increments SP,
// pop decrements SP. dout always shows the top entry (stack[SP-1]).
// Ports:
//   CLK, CLR      clock, asynchronous active-high reset (clears SP only)
//   push, pop     one-cycle strobes; caller guarantees no push when full,
//                 no pop when empty, and never both together
//   din           value to push
//   dout          current top of stack (don't-care when empty)
//   SP            number of stacked entries
//   full, empty   decoded from SP
module return_stack
  import program_counter_stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                    CLK,
  input  logic                    CLR,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic [sp_bits(DEPTH)-1:0] SP,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   SP_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   SP_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] IDX_ONE = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      sp_q;
  logic [AW:0]      sp_d;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;

  // When SP == DEPTH the low bits wrap to 0, so top_idx still lands on DEPTH-1
  assign wr_idx  = sp_q[AW-1:0];
  assign top_idx = sp_q[AW-1:0] - IDX_ONE;

  always_comb begin
    sp_d = sp_q;
    if (push) begin
      sp_d = sp_q + SP_ONE;
    end else if (pop) begin
      sp_d = sp_q - SP_ONE;
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Storage contents are don't-care after reset, so no reset on the array
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_idx] <= din;
    end
  end

  assign dout  = mem_q[top_idx];
  assign SP    = sp_q;
  assign full  = (sp_q == SP_FULL);
  assign empty = (sp_q == '0);

endmodule

// File: rtl/program_counter_stack.sv
// rtl/program_counter_stack.sv - SAP-II program counter with hardware return stack
//
// Purpose: count register with increment (wrap or saturate), jump load,
// CALL/RET through a return stack, sticky error flags and WBUS tri-state.
// Ports:
//   CLK, CLR      clock, asynchronous active-high reset
//   WBUS          system bus; driven with count when Ep = 1, else high-Z
//   Cp, Ep, nLp   increment, drive bus, active-low load
//   CALL, RET     push-and-jump, pop-and-return
//   PC            current count
//   SP            number of stacked entries
//   FULL, EMPTY   stack status
//   ERR           sticky {saturated, underflow, overflow}
module program_counter_stack
  import program_counter_stack_pkg::*;
#(
  parameter int              WIDTH        = DEF_WIDTH,
  parameter int              DEPTH        = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter bit              WRAP         = 1'b1
) (
  input  logic                      CLK,
  input  logic                      CLR,
  inout  wire  [WIDTH-1:0]          WBUS,
  input  logic                      Cp,
  input  logic                      Ep,
  input  logic                      nLp,
  input  logic                      CALL,
  input  logic                      RET,
  output logic [WIDTH-1:0]          PC,
  output logic [sp_bits(DEPTH)-1:0] SP,
  output logic                      FULL,
  output logic                      EMPTY,
  output logic [2:0]                ERR
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [2:0]       err_q, err_d;
  logic             push, pop;
  logic [WIDTH-1:0] stk_top;
  logic             stk_full, stk_empty;

  return_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .CLK   (CLK),
    .CLR   (CLR),
    .push  (push),
    .pop   (pop),
    .din   (count_q),
    .dout  (stk_top),
    .SP    (SP),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Priority: CALL&RET conflict > RET > CALL > load > increment > hold
  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (CALL && RET) begin
      err_d[ERR_OVF] = 1'b1;
      err_d[ERR_UNF] = 1'b1;
    end else if (RET) begin
      if (stk_empty) begin
        err_d[ERR_UNF] = 1'b1;
      end else begin
        pop     = 1'b1;
        count_d = stk_top;
      end
    end else if (CALL) begin
      if (stk_full) begin
        err_d[ERR_OVF] = 1'b1;
      end else begin
        push    = 1'b1;
        count_d = WBUS;
      end
    end else if (!nLp) begin
      count_d = WBUS;
    end else if (Cp) begin
      if (&count_q) begin
        if (WRAP) begin
          count_d = '0;
        end else begin
          err_d[ERR_SAT] = 1'b1;
        end
      end else begin
        count_d = count_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      count_q <= RESET_VECTOR;
      err_q   <= '0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign WBUS  = Ep ? count_q : 'z;
  assign PC    = count_q;
  assign FULL  = stk_full;
  assign EMPTY = stk_empty;
  assign ERR   = err_q;

endmodule
